openofdm_rx_pkt_log: RTL

Per-packet receive status recorder for the OpenOFDM receiver top level. It captures the decoded header fields and RSSI for each packet, then waits for the FCS result or an abort, and commits one timestamped status record into a parametrised first-word-fall-through FIFO. The driver reads the records through the register interface. It sits beside `dot11` in the receiver top and is fed by the same header/FCS strobes that top exports.

---
 rtl/openofdm_rx_pkt_log.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/openofdm_rx_pkt_log.sv
// Per-packet receive status recorder: captures header fields and RSSI, waits for the
// FCS verdict or an abort, and commits one timestamped record into a FWFT FIFO.
module openofdm_rx_pkt_log #(
   parameter int DEPTH_LOG2         = 4,
   parameter int RSSI_HALF_DB_WIDTH = 11,
   parameter int LEN_WIDTH          = 16,
   parameter int TS_WIDTH           = 32,
   localparam int ENTRY_WIDTH       = 12 + LEN_WIDTH + RSSI_HALF_DB_WIDTH + TS_WIDTH
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 pkt_header_valid_strobe,
   input  logic                                 pkt_header_valid,
   input  logic                                 ht_unsupport,
   input  logic [7:0]                           pkt_rate,
   input  logic [LEN_WIDTH-1:0]                 pkt_len,
   input  logic                                 ht_aggr,
   input  logic                                 ht_sgi,
   input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
   input  logic                                 fcs_out_strobe,
   input  logic                                 fcs_ok,
   input  logic                                 demod_is_ongoing,
   input  logic                                 rd_pop,
   output logic                                 rd_valid,
   output logic [ENTRY_WIDTH-1:0]               rd_entry,
   output logic [DEPTH_LOG2:0]                  count,
   output logic [15:0]                          lost_cnt,
   input  logic                                 clear_lost,
   output logic                                 busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   localparam logic [1:0] ST_FCS_BAD = 2'b00;
   localparam logic [1:0] ST_FCS_OK  = 2'b01;
   localparam logic [1:0] ST_HDR_BAD = 2'b10;
   localparam logic [1:0] ST_ABORT   = 2'b11;

   typedef enum logic {IDLE, WAIT_FCS} state_t;

   state_t state, state_nxt;

   logic [TS_WIDTH-1:0]                 ts;
   logic                                demod_p1;
   logic                                demod_fall;

   logic [7:0]                          p_rate;
   logic [LEN_WIDTH-1:0]                p_len;
   logic                                p_aggr;
   logic                                p_sgi;
   logic signed [RSSI_HALF_DB_WIDTH-1:0] p_rssi;
   logic [TS_WIDTH-1:0]                 p_ts;

   logic                                capture;
   logic                                commit;
   logic                                commit_pending;
   logic [1:0]                          commit_status;
   logic                                drop_hdr;
   logic [ENTRY_WIDTH-1:0]              commit_entry;

   logic [ENTRY_WIDTH-1:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]               wr_ptr;
   logic [DEPTH_LOG2-1:0]               rd_ptr;
   logic                                pop_ok;
   logic                                wr_ok;
   logic                                commit_drop;
   logic [1:0]                          loss_inc;

   function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, base} + {15'b0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   assign demod_fall = demod_p1 & ~demod_is_ongoing;
   assign busy       = (state == WAIT_FCS);

   // Commit decision: FCS result outranks a demod fall, which outranks a new header.
   always_comb begin
      state_nxt      = state;
      capture        = 1'b0;
      commit         = 1'b0;
      commit_pending = 1'b0;
      commit_status  = ST_FCS_BAD;
      drop_hdr       = 1'b0;
      case (state)
         IDLE: begin
            if (pkt_header_valid_strobe && enable) begin
               if (!pkt_header_valid || ht_unsupport) begin
                  commit        = 1'b1;
                  commit_status = ST_HDR_BAD;
               end else begin
                  capture   = 1'b1;
                  state_nxt = WAIT_FCS;
               end
            end
         end
         WAIT_FCS: begin
            if (fcs_out_strobe) begin
               commit         = 1'b1;
               commit_pending = 1'b1;
               commit_status  = fcs_ok ? ST_FCS_OK : ST_FCS_BAD;
               state_nxt      = IDLE;
            end else if (demod_fall) begin
               commit         = 1'b1;
               commit_pending = 1'b1;
               commit_status  = ST_ABORT;
               state_nxt      = IDLE;
            end else if (pkt_header_valid_strobe) begin
               commit         = 1'b1;
               commit_pending = 1'b1;
               commit_status  = ST_ABORT;
               drop_hdr       = 1'b1;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if (commit_pending)
         commit_entry = {commit_status, p_sgi, p_aggr, p_rate, p_len, p_rssi, p_ts};
      else
         commit_entry = {commit_status, ht_sgi, ht_aggr, pkt_rate, pkt_len, rssi_half_db, ts};
   end

   // A full FIFO still accepts a write when the head is popped in the same cycle.
   assign pop_ok      = rd_pop && (count != '0);
   assign wr_ok       = commit && ((count != FULL_CNT) || pop_ok);
   assign commit_drop = commit && !wr_ok;
   assign loss_inc    = {1'b0, drop_hdr} + {1'b0, commit_drop};

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         ts       <= '0;
         demod_p1 <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         lost_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ts       <= ts + TS_WIDTH'(1);
         demod_p1 <= demod_is_ongoing;
         if (wr_ok)
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({wr_ok, pop_ok})
            2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
            2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
            default: count <= count;
         endcase
         if (clear_lost)
            lost_cnt <= {14'b0, loss_inc};
         else
            lost_cnt <= sat_add16(lost_cnt, loss_inc);
      end
   end

   // Pending record and FIFO storage are pure data and carry no reset.
   always_ff @(posedge clock) begin
      if (capture) begin
         p_rate <= pkt_rate;
         p_len  <= pkt_len;
         p_aggr <= ht_aggr;
         p_sgi  <= ht_sgi;
         p_rssi <= rssi_half_db;
         p_ts   <= ts;
      end
      if (wr_ok)
         mem[wr_ptr] <= commit_entry;
   end

   assign rd_valid = (count != '0);
   assign rd_entry = rd_valid ? mem[rd_ptr] : '0;

endmodule
